pc_fetch_unit: RTL and testbench



---
 rtl/pc_fetch_pkg.sv | 13 +
 rtl/next_pc_mux.sv | 12 +
 rtl/pc_fetch_unit.sv | 79 +++++++
 tb/tb_pc_fetch_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared types and constants for the PC fetch sequencer
package pc_fetch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetchStateE;

  localparam int          DEFAULT_STEP     = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          FETCH_CNT_W      = 16;

endpackage

// File: rtl/next_pc_mux.sv
// rtl/next_pc_mux.sv - WIDTH-bit 2:1 next-PC select, sel=1 picks the redirect input
module next_pc_mux #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in [2],
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  assign out = sel ? in[1] : in[0];

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and instruction-fetch sequencer with redirect buffering
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
  parameter int               STEP     = DEFAULT_STEP
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [WIDTH-1:0]       branch_target,
  input  logic                   fetch_ready,
  output logic                   fetch_valid,
  output logic [WIDTH-1:0]       pc_out,
  output logic [WIDTH-1:0]       pc_plus_step,
  output logic [FETCH_CNT_W-1:0] fetch_count
);

  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(STEP_W - WIDTH'(1));
  localparam logic [WIDTH-1:0] RESET_ALIGNED = RESET_PC & ALIGN_MASK;

  fetchStateE             state;
  logic [WIDTH-1:0]       pcReg;
  logic                   pendingValid;
  logic [WIDTH-1:0]       pendingTarget;
  logic [FETCH_CNT_W-1:0] fetchCount;

  logic                   accept;
  logic [WIDTH-1:0]       alignedTarget;
  logic [WIDTH-1:0]       redirectAddr;
  logic                   redirectSel;
  logic [WIDTH-1:0]       muxIn [2];
  logic [WIDTH-1:0]       nextPc;

  assign fetch_valid   = (state == RUN) && !stall;
  assign accept        = fetch_valid && fetch_ready;
  assign pc_out        = pcReg;
  assign pc_plus_step  = pcReg + STEP_W;
  assign fetch_count   = fetchCount;

  // A live branch outranks a buffered one; both share the redirect leg of the mux.
  assign alignedTarget = branch_target & ALIGN_MASK;
  assign redirectAddr  = branch_taken ? alignedTarget : pendingTarget;
  assign redirectSel   = branch_taken || pendingValid;
  assign muxIn[0]      = pc_plus_step;
  assign muxIn[1]      = redirectAddr;

  next_pc_mux #(
    .WIDTH(WIDTH)
  ) uNextPcMux (
    .in (muxIn),
    .sel(redirectSel),
    .out(nextPc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pcReg         <= RESET_ALIGNED;
      pendingValid  <= 1'b0;
      pendingTarget <= '0;
      fetchCount    <= '0;
    end else begin
      state <= RUN;
      if (accept) begin
        pcReg        <= nextPc;
        pendingValid <= 1'b0;
        fetchCount   <= fetchCount + FETCH_CNT_W'(1);
      end else if (branch_taken) begin
        pendingValid  <= 1'b1;
        pendingTarget <= alignedTarget;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_step;
  logic [15:0] fetch_count;

  int checks;
  int failures;
  logic [15:0] expCount;

  pc_fetch_unit #(
    .WIDTH   (32),
    .RESET_PC(32'h0000_0100),
    .STEP    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .fetch_ready  (fetch_ready),
    .fetch_valid  (fetch_valid),
    .pc_out       (pc_out),
    .pc_plus_step (pc_plus_step),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jump_to(input logic [31:0] addr);
    fetch_ready   = 1'b1;
    branch_taken  = 1'b1;
    branch_target = addr;
    tick();
    branch_taken  = 1'b0;
    expCount      = expCount + 16'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; fetch_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (pc_out !== 32'h100 || fetch_valid !== 1'b0 || fetch_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_state pc=%h valid=%b cnt=%0d want pc=100 valid=0 cnt=0", pc_out, fetch_valid, fetch_count);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (fetch_valid !== 1'b0 || pc_out !== 32'h100) begin
      failures++;
      $display("FAIL idle_cycle valid=%b pc=%h want valid=0 pc=100", fetch_valid, pc_out);
    end
    tick();
    checks++;
    if (fetch_valid !== 1'b1 || pc_out !== 32'h100 || pc_plus_step !== 32'h104) begin
      failures++;
      $display("FAIL first_valid valid=%b pc=%h pps=%h want valid=1 pc=100 pps=104", fetch_valid, pc_out, pc_plus_step);
    end
    tick();
    checks++;
    if (pc_out !== 32'h104) begin
      failures++;
      $display("FAIL seq_104 pc=%h want 104", pc_out);
    end
    tick();
    checks++;
    if (pc_out !== 32'h108) begin
      failures++;
      $display("FAIL seq_108 pc=%h want 108", pc_out);
    end
    tick();
    expCount = 16'd3;
    checks++;
    if (fetch_count !== 16'd3 || pc_out !== 32'h10C) begin
      failures++;
      $display("FAIL count_3 cnt=%0d pc=%h want cnt=3 pc=10c", fetch_count, pc_out);
    end
  endtask

  task automatic test_backpressure();
    jump_to(32'h200);
    fetch_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (pc_out !== 32'h200 || fetch_count !== expCount || fetch_valid !== 1'b1) begin
        failures++;
        $display("FAIL backpressure_hold[%0d] pc=%h cnt=%0d valid=%b want pc=200 cnt=%0d valid=1", i, pc_out, fetch_count, fetch_valid, expCount);
      end
    end
    fetch_ready = 1'b1;
    tick();
    expCount = expCount + 16'd1;
    checks++;
    if (pc_out !== 32'h204 || fetch_count !== expCount) begin
      failures++;
      $display("FAIL backpressure_release pc=%h cnt=%0d want pc=204 cnt=%0d", pc_out, fetch_count, expCount);
    end
  endtask

  task automatic test_redirect_not_ready();
    jump_to(32'h300);
    fetch_ready   = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h403;
    tick();
    branch_taken  = 1'b0;
    tick();
    checks++;
    if (pc_out !== 32'h300) begin
      failures++;
      $display("FAIL redirect_stable pc=%h want 300", pc_out);
    end
    fetch_ready = 1'b1;
    tick();
    checks++;
    if (pc_out !== 32'h400) begin
      failures++;
      $display("FAIL redirect_aligned pc=%h want 400", pc_out);
    end
    tick();
    expCount = expCount + 16'd2;
    checks++;
    if (pc_out !== 32'h404 || fetch_count !== expCount) begin
      failures++;
      $display("FAIL redirect_follow pc=%h cnt=%0d want pc=404 cnt=%0d", pc_out, fetch_count, expCount);
    end
  endtask

  task automatic test_same_cycle();
    fetch_ready   = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h500;
    tick();
    fetch_ready   = 1'b1;
    branch_target = 32'h600;
    tick();
    branch_taken  = 1'b0;
    checks++;
    if (pc_out !== 32'h600) begin
      failures++;
      $display("FAIL same_cycle_branch pc=%h want 600", pc_out);
    end
    tick();
    expCount = expCount + 16'd2;
    checks++;
    if (pc_out !== 32'h604 || fetch_count !== expCount) begin
      failures++;
      $display("FAIL stale_pending_dropped pc=%h cnt=%0d want pc=604 cnt=%0d", pc_out, fetch_count, expCount);
    end
  endtask

  task automatic test_stall_wrap();
    stall = 1'b1;
    fetch_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (fetch_valid !== 1'b0 || pc_out !== 32'h604 || fetch_count !== expCount) begin
        failures++;
        $display("FAIL stall_hold[%0d] valid=%b pc=%h cnt=%0d want valid=0 pc=604 cnt=%0d", i, fetch_valid, pc_out, fetch_count, expCount);
      end
    end
    stall = 1'b0;
    jump_to(32'hFFFF_FFFC);
    checks++;
    if (pc_out !== 32'hFFFF_FFFC || pc_plus_step !== 32'h0) begin
      failures++;
      $display("FAIL top_of_space pc=%h pps=%h want pc=fffffffc pps=0", pc_out, pc_plus_step);
    end
    tick();
    expCount = expCount + 16'd1;
    checks++;
    if (pc_out !== 32'h0 || fetch_count !== expCount) begin
      failures++;
      $display("FAIL pc_wrap pc=%h cnt=%0d want pc=0 cnt=%0d", pc_out, fetch_count, expCount);
    end
  endtask

  task automatic test_reset_mid();
    fetch_ready   = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h700;
    tick();
    rst           = 1'b1;
    fetch_ready   = 1'b1;
    branch_target = 32'h800;
    tick();
    rst           = 1'b0;
    branch_taken  = 1'b0;
    expCount      = 16'd0;
    checks++;
    if (pc_out !== 32'h100 || fetch_count !== 16'd0 || fetch_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid pc=%h cnt=%0d valid=%b want pc=100 cnt=0 valid=0", pc_out, fetch_count, fetch_valid);
    end
    tick();
    tick();
    expCount = 16'd1;
    checks++;
    if (pc_out !== 32'h104 || fetch_count !== expCount) begin
      failures++;
      $display("FAIL pending_lost pc=%h cnt=%0d want pc=104 cnt=1", pc_out, fetch_count);
    end
  endtask

  task automatic test_count_wrap();
    fetch_ready = 1'b1;
    while (expCount != 16'hFFFF) begin
      tick();
      expCount = expCount + 16'd1;
    end
    checks++;
    if (fetch_count !== 16'hFFFF) begin
      failures++;
      $display("FAIL count_max cnt=%h want ffff", fetch_count);
    end
    tick();
    checks++;
    if (fetch_count !== 16'h0000) begin
      failures++;
      $display("FAIL count_wrap cnt=%h want 0000", fetch_count);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    expCount = 16'd0;
    test_reset();
    test_backpressure();
    test_redirect_not_ready();
    test_same_cycle();
    test_stall_wrap();
    test_reset_mid();
    test_count_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
